csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
Sequencer and arbiter in front of the machine-mode CSR register file. It owns the file's single access port and shares it between core CSR instructions, trap entry (exception/interrupt) and mret. Trap entry and mret each run as a fixed multi-cycle read-modify-write sequence over mstatus/mepc/mcause/mtvec/mepc. It returns the redirect PC to the fetch unit.

Parameters:
XLEN, 32, CSR data and PC width
MTVEC_VEC_BITS, 5, number of cause bits used for vectored interrupt offset

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
core_req_i  in  1  core CSR access request; held until core_gnt_o
core_we_i  in  1  1 = write, 0 = read
core_addr_i  in  12  CSR address
core_wdata_i  in  32  write data
core_gnt_o  out  1  one-cycle pulse: request accepted (write done / read issued)
core_err_o  out  1  pulses with core_gnt_o: unimplemented address or write to read-only CSR
core_rvalid_o  out  1  one-cycle pulse, read data valid
core_rdata_o  out  32  read data, valid only when core_rvalid_o
trap_req_i  in  1  trap request; held with cause/pc until trap_ack_o
trap_cause_i  in  32  mcause value; bit31 = interrupt
trap_pc_i  in  32  PC of trapping instruction
trap_ack_o  out  1  one-cycle pulse, trap entry complete
mret_req_i  in  1  mret request; held until mret_ack_o
mret_ack_o  out  1  one-cycle pulse, mret complete
redirect_valid_o  out  1  pulses with trap_ack_o or mret_ack_o
redirect_pc_o  out  32  new fetch PC, valid with redirect_valid_o
csr_addr_o  out  32  CSR file address (12-bit address zero-extended)
csr_we_o  out  1  CSR file write enable
csr_re_o  out  1  CSR file read enable
csr_wdata_o  out  32  CSR file write data
csr_rdata_i  in  32  CSR file read data; valid the cycle after csr_re_o
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_ni low, async): state IDLE; all outputs 0; latched cause/pc/mstatus/mtvec registers 0. Reset mid-sequence abandons it, with no ack and no redirect.
- csr_we_o and csr_re_o are never both 1. Unused csr_* outputs are 0 outside their states.
- IDLE arbitration (fixed priority): trap > mret > core. Accepting a trap latches trap_cause_i and trap_pc_i.
- Core write, implemented writable address: CORE_WR state for one cycle with csr_we_o=1 and core_gnt_o=1, then IDLE.
- Core write to 0xF11–0xF14, or any access to an unimplemented address: CORE_WR/CORE_RD state with no csr_we_o/csr_re_o, core_gnt_o=1, core_err_o=1. Reads return core_rvalid_o=1 with rdata 0 the next cycle.
- Core read: CORE_RD (csr_re_o=1, core_gnt_o=1), then CORE_RDW (core_rvalid_o=1, core_rdata_o=csr_rdata_i), then IDLE.
- Trap sequence, one state per cycle:
  - T_RD_MST: read 0x300.
  - T_W_MST: capture mstatus.
  - T_WR_MEPC: write 0x341 = pc & ~3.
  - T_WR_MCAUSE: write 0x342 = cause.
  - T_WR_MST: write 0x300 with MPIE(7) <- MIE(3), MIE <- 0, MPP(12:11) <- 2'b11, other bits unchanged.
  - T_RD_TVEC: read 0x305.
  - T_W_TVEC: capture mtvec.
  - T_DONE: trap_ack_o=1, redirect_valid_o=1.
  - Latency: ack 8 cycles after the IDLE acceptance cycle.
- Redirect target: base = mtvec & ~3.
  - mtvec[1:0]==1 and cause[31]==1: base + (cause[MTVEC_VEC_BITS-1:0] << 2).
  - Otherwise: base. Mode 2/3 is treated as direct.
  - Addition wraps modulo 2^32.
- Mret sequence:
  - M_RD_MST / M_W_MST: read and capture mstatus.
  - M_WR_MST: write MIE <- MPIE, MPIE <- 1, MPP <- 2'b11.
  - M_RD_MEPC / M_W_MEPC: read and capture 0x341.
  - M_DONE: mret_ack_o=1, redirect_pc_o = mepc.
  - Latency: ack 6 cycles after acceptance.
- A request arriving while busy waits; no preemption. A trap raised during mret or a core access is serviced on the next IDLE cycle. Simultaneous trap+mret+core in IDLE: trap served first, mret next, core last.

Decomposition:
- Package csr_pkg holds:
  - 12-bit CSR address constants (MISA 0x301, MVENDORID 0xF11, MARCHID 0xF12, MIMPID 0xF13, MHARTID 0xF14, MCAUSE 0x342, MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MIP 0x344, MIE 0x304, MCYCLE 0xB00, MCYCLEH 0xB80, MINSTRET 0xB02, MINSTRETH 0xB82, MCOUNTEREN 0x306).
  - mstatus bit-position constants: MIE 3, MPIE 7, MPP 12:11.
  - The FSM state enum.
- One sub-module, csr_addr_decode: combinational; address -> implemented and read_only flags.

Test Plan:
- Core write 0x305 = 0x8000_0101, then core read 0x305 -> gnt pulses; rvalid one cycle after read gnt with rdata 0x8000_0101.
- mstatus=0x8, mtvec=0x200, trap cause=2, pc=0x1006 -> ack 8 cycles after acceptance; mepc=0x1004, mcause=2, mstatus=0x1880, redirect_pc=0x200.
- mtvec=0x8000_0101, trap cause=0x8000_0007 -> redirect_pc=0x8000_011C. Same cause with mtvec=0x8000_0100 -> 0x8000_0100.
- mstatus=0x1880, mepc=0x1004, mret -> mstatus=0x1888, redirect_pc=0x1004, ack 6 cycles after acceptance.
- Core write to 0xF11, or read of 0x7C0 -> core_err_o=1 with gnt; no csr_we_o/csr_re_o; read returns 0.
- trap, mret and core read all asserted in the same IDLE cycle -> trap, then mret, then core served in order. Separately: rst_ni low during T_WR_MCAUSE -> all outputs 0, no ack, IDLE after release.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR trap controller: CSR addresses,
// mstatus field positions and the sequencer state encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;
    localparam logic [11:0] CSR_MIMPID     = 12'hF13;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [4:0] {
        IDLE,
        CORE_WR,
        CORE_RD,
        CORE_RDW,
        T_RD_MST,
        T_W_MST,
        T_WR_MEPC,
        T_WR_MCAUSE,
        T_WR_MST,
        T_RD_TVEC,
        T_W_TVEC,
        T_DONE,
        M_RD_MST,
        M_W_MST,
        M_WR_MST,
        M_RD_MEPC,
        M_W_MEPC,
        M_DONE
    } state_t;

endpackage

// File: rtl/csr_addr_decode.sv
// Classifies a CSR address as implemented and/or read-only (the machine
// information registers).
module csr_addr_decode
    import csr_pkg::*;
(
    input  logic [11:0] addr,
    output logic        implemented,
    output logic        read_only
);

    always_comb begin
        implemented = 1'b0;
        read_only   = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MCOUNTEREN,
            CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
            CSR_MCYCLEH, CSR_MINSTRETH: begin
                implemented = 1'b1;
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: begin
                implemented = 1'b1;
                read_only   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Owns the single CSR file port and sequences core accesses, trap entry and
// mret over it; returns the redirect PC to fetch.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int MTVEC_VEC_BITS = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [11:0]     core_addr_i,
    input  logic [XLEN-1:0] core_wdata_i,
    output logic            core_gnt_o,
    output logic            core_err_o,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    output logic            trap_ack_o,
    input  logic            mret_req_i,
    output logic            mret_ack_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [XLEN-1:0] csr_addr_o,
    output logic            csr_we_o,
    output logic            csr_re_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            busy_o
);

    state_t          state, state_next;
    logic [XLEN-1:0] cause_q, pc_q, mstatus_q, mtvec_q;
    logic            rd_err_q;
    logic            core_impl, core_ro, core_bad;
    logic [11:0]     csr_addr12;
    logic [XLEN-1:0] tvec_base, tvec_offset, trap_target;
    logic [XLEN-1:0] mst_trap, mst_mret;

    csr_addr_decode u_decode (
        .addr        (core_addr_i),
        .implemented (core_impl),
        .read_only   (core_ro)
    );

    // Core inputs are held until the grant, so they are decoded live in CORE_WR/CORE_RD.
    assign core_bad = !core_impl || (core_we_i && core_ro);

    assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
    assign tvec_offset = {{(XLEN-MTVEC_VEC_BITS-2){1'b0}}, cause_q[MTVEC_VEC_BITS-1:0], 2'b00};
    assign trap_target = (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1]) ? tvec_base + tvec_offset
                                                                     : tvec_base;

    always_comb begin
        mst_trap = mstatus_q;
        mst_trap[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
        mst_trap[MSTATUS_MIE]  = 1'b0;
        mst_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mst_mret = mstatus_q;
        mst_mret[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
        mst_mret[MSTATUS_MPIE] = 1'b1;
        mst_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // pc_q doubles as the captured mepc during mret, which is what gets redirected to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cause_q   <= '0;
            pc_q      <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_req_i) begin
                        cause_q <= trap_cause_i;
                        pc_q    <= trap_pc_i;
                    end
                end
                CORE_RD:          rd_err_q  <= core_bad;
                T_W_MST, M_W_MST: mstatus_q <= csr_rdata_i;
                T_W_TVEC:         mtvec_q   <= csr_rdata_i;
                M_W_MEPC:         pc_q      <= csr_rdata_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next       = state;
        core_gnt_o       = 1'b0;
        core_err_o       = 1'b0;
        core_rvalid_o    = 1'b0;
        core_rdata_o     = '0;
        trap_ack_o       = 1'b0;
        mret_ack_o       = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        csr_addr12       = 12'h000;
        csr_we_o         = 1'b0;
        csr_re_o         = 1'b0;
        csr_wdata_o      = '0;
        case (state)
            IDLE: begin
                if (trap_req_i) begin
                    state_next = T_RD_MST;
                end else if (mret_req_i) begin
                    state_next = M_RD_MST;
                end else if (core_req_i) begin
                    state_next = core_we_i ? CORE_WR : CORE_RD;
                end
            end
            CORE_WR: begin
                core_gnt_o = 1'b1;
                core_err_o = core_bad;
                if (!core_bad) begin
                    csr_we_o    = 1'b1;
                    csr_addr12  = core_addr_i;
                    csr_wdata_o = core_wdata_i;
                end
                state_next = IDLE;
            end
            CORE_RD: begin
                core_gnt_o = 1'b1;
                core_err_o = core_bad;
                if (!core_bad) begin
                    csr_re_o   = 1'b1;
                    csr_addr12 = core_addr_i;
                end
                state_next = CORE_RDW;
            end
            CORE_RDW: begin
                core_rvalid_o = 1'b1;
                core_rdata_o  = rd_err_q ? '0 : csr_rdata_i;
                state_next    = IDLE;
            end
            T_RD_MST: begin
                csr_re_o   = 1'b1;
                csr_addr12 = CSR_MSTATUS;
                state_next = T_W_MST;
            end
            T_W_MST: state_next = T_WR_MEPC;
            T_WR_MEPC: begin
                csr_we_o    = 1'b1;
                csr_addr12  = CSR_MEPC;
                csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
                state_next  = T_WR_MCAUSE;
            end
            T_WR_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_addr12  = CSR_MCAUSE;
                csr_wdata_o = cause_q;
                state_next  = T_WR_MST;
            end
            T_WR_MST: begin
                csr_we_o    = 1'b1;
                csr_addr12  = CSR_MSTATUS;
                csr_wdata_o = mst_trap;
                state_next  = T_RD_TVEC;
            end
            T_RD_TVEC: begin
                csr_re_o   = 1'b1;
                csr_addr12 = CSR_MTVEC;
                state_next = T_W_TVEC;
            end
            T_W_TVEC: state_next = T_DONE;
            T_DONE: begin
                trap_ack_o       = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = trap_target;
                state_next       = IDLE;
            end
            M_RD_MST: begin
                csr_re_o   = 1'b1;
                csr_addr12 = CSR_MSTATUS;
                state_next = M_W_MST;
            end
            M_W_MST: state_next = M_WR_MST;
            M_WR_MST: begin
                csr_we_o    = 1'b1;
                csr_addr12  = CSR_MSTATUS;
                csr_wdata_o = mst_mret;
                state_next  = M_RD_MEPC;
            end
            M_RD_MEPC: begin
                csr_re_o   = 1'b1;
                csr_addr12 = CSR_MEPC;
                state_next = M_W_MEPC;
            end
            M_W_MEPC: state_next = M_DONE;
            M_DONE: begin
                mret_ack_o       = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = pc_q;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign csr_addr_o = {{(XLEN-12){1'b0}}, csr_addr12};
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: a behavioural CSR file answers the
// DUT port, a table of core vectors, directed trap/mret sequences, random mix.
module tb_csr_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i, core_we_i;
    logic [11:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic        core_gnt_o, core_err_o, core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        trap_req_i;
    logic [31:0] trap_cause_i, trap_pc_i;
    logic        trap_ack_o, mret_req_i, mret_ack_o, redirect_valid_o;
    logic [31:0] redirect_pc_o, csr_addr_o, csr_wdata_o, csr_rdata_i;
    logic        csr_we_o, csr_re_o, busy_o;

    always #5 clk_i = ~clk_i;

    csr_trap_ctrl #(.XLEN(32), .MTVEC_VEC_BITS(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_err_o(core_err_o),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .trap_ack_o(trap_ack_o), .mret_req_i(mret_req_i), .mret_ack_o(mret_ack_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_re_o(csr_re_o),
        .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    // Environment: CSR register file with one-cycle read latency
    logic [31:0] csr_mem [0:4095];
    logic        env_clear;

    always @(posedge clk_i) begin
        if (env_clear) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
            csr_mem[12'hF11] <= 32'h0000_0A5A;
            csr_rdata_i <= 32'h0;
        end else begin
            if (csr_we_o) csr_mem[csr_addr_o[11:0]] <= csr_wdata_o;
            csr_rdata_i <= csr_re_o ? csr_mem[csr_addr_o[11:0]] : $urandom;
        end
    end

    always @(negedge clk_i) if (csr_we_o && csr_re_o) overlap++;

    // Reference model: architectural CSR contents
    logic [31:0] ref_csr [0:4095];

    function automatic logic m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h341, 12'h342, 12'h344,
            12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_ro(input logic [11:0] a);
        return (a >= 12'hF11) && (a <= 12'hF14);
    endfunction

    function automatic logic [31:0] m_trap_status(input logic [31:0] s);
        return (s & ~32'h0000_0088) | (((s >> 3) & 32'h1) << 7) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] m_mret_status(input logic [31:0] s);
        return (s & ~32'h0000_0008) | (((s >> 7) & 32'h1) << 3) | 32'h0000_1880;
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] base;
        base = tvec & ~32'h3;
        if ((tvec & 32'h3) == 32'h1 && cause[31]) return base + ((cause & 32'h1F) << 2);
        return base;
    endfunction

    task automatic model_core(input logic we, input logic [11:0] a, input logic [31:0] wd,
                              output logic exp_err, output logic [31:0] exp_rd);
        exp_err = !m_impl(a) || (we && m_ro(a));
        exp_rd  = (!we && !exp_err) ? ref_csr[a] : 32'h0;
        if (we && !exp_err) ref_csr[a] = wd;
    endtask

    task automatic model_trap(input logic [31:0] cause, input logic [31:0] pc, output logic [31:0] exp_pc);
        ref_csr[12'h341] = pc & ~32'h3;
        ref_csr[12'h342] = cause;
        ref_csr[12'h300] = m_trap_status(ref_csr[12'h300]);
        exp_pc = m_target(ref_csr[12'h305], cause);
    endtask

    task automatic model_mret(output logic [31:0] exp_pc);
        ref_csr[12'h300] = m_mret_status(ref_csr[12'h300]);
        exp_pc = ref_csr[12'h341];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drivers: each starts and ends on a negedge with the DUT idle
    task automatic core_access(input logic we, input logic [11:0] a, input logic [31:0] wd,
                               output int lat, output logic err, output logic rv,
                               output logic [31:0] rd, output logic bad_port);
        core_req_i = 1'b1; core_we_i = we; core_addr_i = a; core_wdata_i = wd;
        lat = 999; err = 1'b0; rv = 1'b0; rd = 32'h0; bad_port = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (core_gnt_o) begin
                lat = i;
                err = core_err_o;
                bad_port = (csr_we_o !== (!core_err_o && we)) || (csr_re_o !== (!core_err_o && !we)) ||
                           ((csr_we_o || csr_re_o) && csr_addr_o !== {20'h0, a});
                break;
            end
        end
        core_req_i = 1'b0;
        if (!we && lat != 999) begin
            @(negedge clk_i);
            rv = core_rvalid_o;
            rd = core_rdata_o;
        end
        @(negedge clk_i);
    endtask

    task automatic trap_access(input logic [31:0] cause, input logic [31:0] pc, output int lat,
                               output logic [31:0] rpc, output logic rvld, output logic after);
        trap_req_i = 1'b1; trap_cause_i = cause; trap_pc_i = pc;
        lat = 999; rpc = 32'h0; rvld = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_i);
            if (trap_ack_o) begin lat = i; rpc = redirect_pc_o; rvld = redirect_valid_o; break; end
        end
        trap_req_i = 1'b0;
        @(negedge clk_i);
        after = trap_ack_o | busy_o;
    endtask

    task automatic mret_access(output int lat, output logic [31:0] rpc, output logic rvld);
        mret_req_i = 1'b1;
        lat = 999; rpc = 32'h0; rvld = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_i);
            if (mret_ack_o) begin lat = i; rpc = redirect_pc_o; rvld = redirect_valid_o; break; end
        end
        mret_req_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic do_core(input string tag, input logic we, input logic [11:0] a, input logic [31:0] wd);
        int lat; logic err, rv, bp, e_err; logic [31:0] rd, e_rd;
        core_access(we, a, wd, lat, err, rv, rd, bp);
        model_core(we, a, wd, e_err, e_rd);
        checkOutput({tag, "_gnt_lat"}, 32'(lat), 32'd1);
        checkOutput({tag, "_err"}, 32'(err), 32'(e_err));
        checkOutput({tag, "_port"}, 32'(bp), 32'd0);
        if (!we) begin
            checkOutput({tag, "_rvalid"}, 32'(rv), 32'd1);
            checkOutput({tag, "_rdata"}, rd, e_rd);
        end
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } core_vec_t;

    core_vec_t vecs [10];

    task automatic applyStimulus(input core_vec_t v, input int idx);
        int lat; logic err, rv, bp, d_err; logic [31:0] rd, d_rd;
        core_access(v.we, v.addr, v.wdata, lat, err, rv, rd, bp);
        model_core(v.we, v.addr, v.wdata, d_err, d_rd);
        checkOutput($sformatf("vec%0d_gnt_lat", idx), 32'(lat), 32'd1);
        checkOutput($sformatf("vec%0d_err", idx), 32'(err), 32'(v.exp_err));
        checkOutput($sformatf("vec%0d_port", idx), 32'(bp), 32'd0);
        if (!v.we) begin
            checkOutput($sformatf("vec%0d_rvalid", idx), 32'(rv), 32'd1);
            checkOutput($sformatf("vec%0d_rdata", idx), rd, v.exp_rdata);
        end
    endtask

    function automatic logic [31:0] outs_any();
        return {19'h0, core_gnt_o, core_err_o, core_rvalid_o, trap_ack_o, mret_ack_o,
                redirect_valid_o, csr_we_o, csr_re_o, busy_o,
                |core_rdata_o, |redirect_pc_o, |csr_addr_o, |csr_wdata_o};
    endfunction

    logic [11:0] pool [12] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h304, 12'h344,
                               12'hB00, 12'hF11, 12'hF14, 12'h7C0, 12'h123, 12'h306};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat; logic rv, after, ack_seen; logic [31:0] rpc, e_pc, e_pc2, e_rd, saved_cause;
        logic e_err; int t_at, m_at, g_at, r_at; logic [31:0] t_pc, m_pc, r_data;

        vecs[0] = '{1'b1, 12'h305, 32'h8000_0101, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 12'h305, 32'h0,         1'b0, 32'h8000_0101};
        vecs[2] = '{1'b1, 12'hF11, 32'h1234_5678, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 12'h7C0, 32'h0,         1'b1, 32'h0};
        vecs[4] = '{1'b0, 12'hF11, 32'h0,         1'b0, 32'h0000_0A5A};
        vecs[5] = '{1'b1, 12'h300, 32'h0000_0008, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 12'h300, 32'h0,         1'b0, 32'h0000_0008};
        vecs[7] = '{1'b1, 12'h7C0, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[8] = '{1'b1, 12'hB00, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 12'hB00, 32'h0,         1'b0, 32'hCAFE_F00D};

        for (int i = 0; i < 4096; i++) ref_csr[i] = 32'h0;
        ref_csr[12'hF11] = 32'h0000_0A5A;

        core_req_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0;
        trap_req_i = 0; trap_cause_i = 0; trap_pc_i = 0; mret_req_i = 0;
        env_clear = 1'b1;
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;
        #1 checkOutput("reset_outputs_zero", outs_any(), 32'h0);
        repeat (3) @(negedge clk_i);
        env_clear = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("reset_release_idle", 32'(busy_o), 32'd0);

        $display("[TB] core access vector table");
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

        $display("[TB] trap entry, direct mode");
        do_core("setup_mst", 1'b1, 12'h300, 32'h0000_0008);
        do_core("setup_tvec", 1'b1, 12'h305, 32'h0000_0200);
        model_trap(32'h2, 32'h1006, e_pc);
        trap_access(32'h2, 32'h1006, lat, rpc, rv, after);
        checkOutput("trap_latency", 32'(lat), 32'd8);
        checkOutput("trap_redirect_pc", rpc, 32'h0000_0200);
        checkOutput("trap_redirect_valid", 32'(rv), 32'd1);
        checkOutput("trap_ack_single_pulse", 32'(after), 32'd0);
        checkOutput("trap_mepc", csr_mem[12'h341], 32'h0000_1004);
        checkOutput("trap_mcause", csr_mem[12'h342], 32'h0000_0002);
        checkOutput("trap_mstatus", csr_mem[12'h300], 32'h0000_1880);

        $display("[TB] trap entry, vectored mode");
        do_core("setup_tvec_vec", 1'b1, 12'h305, 32'h8000_0101);
        model_trap(32'h8000_0007, 32'h0000_2000, e_pc);
        trap_access(32'h8000_0007, 32'h0000_2000, lat, rpc, rv, after);
        checkOutput("trap_vectored_pc", rpc, 32'h8000_011C);
        do_core("setup_tvec_dir", 1'b1, 12'h305, 32'h8000_0100);
        model_trap(32'h8000_0007, 32'h0000_2000, e_pc);
        trap_access(32'h8000_0007, 32'h0000_2000, lat, rpc, rv, after);
        checkOutput("trap_direct_irq_pc", rpc, 32'h8000_0100);

        $display("[TB] mret");
        do_core("setup_mst2", 1'b1, 12'h300, 32'h0000_1880);
        do_core("setup_mepc", 1'b1, 12'h341, 32'h0000_1004);
        model_mret(e_pc);
        mret_access(lat, rpc, rv);
        checkOutput("mret_latency", 32'(lat), 32'd6);
        checkOutput("mret_redirect_pc", rpc, 32'h0000_1004);
        checkOutput("mret_redirect_valid", 32'(rv), 32'd1);
        checkOutput("mret_mstatus", csr_mem[12'h300], 32'h0000_1888);

        $display("[TB] simultaneous trap, mret and core read");
        model_trap(32'h0000_000B, 32'h0000_4443, e_pc);
        model_mret(e_pc2);
        model_core(1'b0, 12'h341, 32'h0, e_err, e_rd);
        trap_req_i = 1'b1; trap_cause_i = 32'h0000_000B; trap_pc_i = 32'h0000_4443;
        mret_req_i = 1'b1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 12'h341; core_wdata_i = 32'h0;
        t_at = 0; m_at = 0; g_at = 0; r_at = 0; t_pc = 0; m_pc = 0; r_data = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_i);
            if (trap_ack_o) begin t_at = i; t_pc = redirect_pc_o; trap_req_i = 1'b0; end
            if (mret_ack_o) begin m_at = i; m_pc = redirect_pc_o; mret_req_i = 1'b0; end
            if (core_gnt_o) begin g_at = i; core_req_i = 1'b0; end
            if (core_rvalid_o) begin r_at = i; r_data = core_rdata_o; break; end
        end
        trap_req_i = 1'b0; mret_req_i = 1'b0; core_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("prio_trap_at", 32'(t_at), 32'd8);
        checkOutput("prio_mret_at", 32'(m_at), 32'd15);
        checkOutput("prio_core_gnt_at", 32'(g_at), 32'd17);
        checkOutput("prio_core_rvalid_at", 32'(r_at), 32'd18);
        checkOutput("prio_trap_pc", t_pc, e_pc);
        checkOutput("prio_mret_pc", m_pc, e_pc2);
        checkOutput("prio_core_rdata", r_data, e_rd);

        $display("[TB] randomized mix");
        for (int n = 0; n < 80; n++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                do_core($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)], $urandom);
            end else if (op == 2) begin
                logic [31:0] c, p;
                c = $urandom; p = $urandom;
                model_trap(c, p, e_pc);
                trap_access(c, p, lat, rpc, rv, after);
                checkOutput($sformatf("rnd%0d_trap_lat", n), 32'(lat), 32'd8);
                checkOutput($sformatf("rnd%0d_trap_pc", n), rpc, e_pc);
            end else begin
                model_mret(e_pc);
                mret_access(lat, rpc, rv);
                checkOutput($sformatf("rnd%0d_mret_lat", n), 32'(lat), 32'd6);
                checkOutput($sformatf("rnd%0d_mret_pc", n), rpc, e_pc);
            end
        end
        for (int i = 0; i < 12; i++)
            checkOutput($sformatf("final_csr_%h", pool[i]), csr_mem[pool[i]], ref_csr[pool[i]]);

        $display("[TB] reset during trap sequence");
        saved_cause = ref_csr[12'h342];
        trap_req_i = 1'b1; trap_cause_i = 32'h7FFF_FFF3; trap_pc_i = 32'h0000_8000;
        repeat (4) @(negedge clk_i);
        checkOutput("rst_mid_in_mcause_write", {19'h0, csr_we_o, csr_addr_o[11:0]}, {19'h0, 1'b1, 12'h342});
        rst_ni = 1'b0;
        #1 checkOutput("rst_mid_outputs_zero", outs_any(), 32'h0);
        trap_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (trap_ack_o || redirect_valid_o || busy_o) ack_seen = 1'b1;
        end
        checkOutput("rst_mid_no_ack_idle", 32'(ack_seen), 32'd0);
        checkOutput("rst_mid_mcause_untouched", csr_mem[12'h342], saved_cause);

        checkOutput("we_re_never_both", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
